// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared types and constants for the instruction-memory boot loader
package boot_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_WR,
    S_CHK,
    S_RUN,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [3:0] OP_LDM = 4'b0000;
  localparam logic [3:0] OP_STM = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_LDI = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_JZ  = 4'b0101;

endpackage

// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - byte stream in, instruction-memory write port out
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
);

  logic [boot_pkg::BYTE_W-1:0] rx_data;
  logic                        rx_valid;
  logic                        rx_ready;
  logic                        imem_we;
  logic [ADDR_W-1:0]           imem_addr;
  logic [boot_pkg::WORD_W-1:0] imem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/run_timer.sv
// rtl/run_timer.sv - counts cycles spent in RUN, saturating, and flags the last allowed cycle
module run_timer
  import boot_pkg::*;
#(
  parameter int MAX_RUN = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  output logic [WORD_W-1:0] run_cycles,
  output logic              expired
);

  logic [WORD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High during the MAX_RUN-th RUN cycle so the FSM leaves RUN after exactly MAX_RUN cycles.
  assign expired    = en && (MAX_RUN != 0) && (32'(cnt_q) == MAX_RUN - 1);
  assign run_cycles = cnt_q;

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads a checksummed byte-stream image into instruction memory
// and then releases the processor via cpu_ready.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 8,
  parameter int MAX_RUN    = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  imem_boot_loader_if.slave        bus,
  output logic                     cpu_ready,
  input  logic                     reload,
  output logic                     done,
  output logic                     err,
  output logic [WORD_W-1:0]        run_cycles
);

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] n_q, n_d, idx_q, idx_d, sum_q, sum_d, hi_q, hi_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              cpu_ready_q, cpu_ready_d, done_q, done_d, err_q, err_d;
  logic              rx_ready, accept, reload_ok, run_en, run_expired;

  assign rx_ready  = (state_q == S_LEN) || (state_q == S_HI) ||
                     (state_q == S_LO)  || (state_q == S_CHK);
  assign accept    = rx_ready && bus.rx_valid;
  assign reload_ok = reload && ((state_q == S_RUN) || (state_q == S_DONE) || (state_q == S_ERR));
  assign run_en    = (state_q == S_RUN);

  run_timer #(.MAX_RUN(MAX_RUN)) u_run_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (run_en),
    .clr        (reload_ok),
    .run_cycles (run_cycles),
    .expired    (run_expired)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: state_d = S_LEN;
      S_LEN: if (accept) begin
        sum_d = '0;
        idx_d = '0;
        n_d   = bus.rx_data;
        if (32'(bus.rx_data) > IMEM_DEPTH) state_d = S_ERR;
        else if (bus.rx_data == '0)        state_d = S_CHK;
        else                               state_d = S_HI;
      end
      S_HI: if (accept) begin
        hi_d    = bus.rx_data;
        sum_d   = sum_q + bus.rx_data;
        state_d = S_LO;
      end
      // Address and data are registered here so they line up with the WR-cycle strobe.
      S_LO: if (accept) begin
        addr_d  = ADDR_W'(idx_q);
        wdata_d = {hi_q, bus.rx_data};
        sum_d   = sum_q + bus.rx_data;
        state_d = S_WR;
      end
      S_WR: begin
        if (idx_q == n_q - 8'd1) begin
          state_d = S_CHK;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_HI;
        end
      end
      S_CHK: if (accept) state_d = (bus.rx_data == sum_q) ? S_RUN : S_ERR;
      S_RUN: begin
        if (reload_ok)        state_d = S_LEN;
        else if (run_expired) state_d = S_DONE;
      end
      S_DONE, S_ERR: if (reload_ok) state_d = S_LEN;
      default: state_d = S_IDLE;
    endcase
    imem_we_d   = (state_d == S_WR);
    cpu_ready_d = (state_d == S_RUN);
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      hi_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      imem_we_q   <= 1'b0;
      cpu_ready_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      hi_q        <= hi_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      imem_we_q   <= imem_we_d;
      cpu_ready_q <= cpu_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.rx_ready   = rx_ready;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_ready      = cpu_ready_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule
